// File: rtl/two_bit_counter_pkg.sv
// Shared types, mode encodings and the Gray-step helper for the 2-bit counter.
package two_bit_counter_pkg;

  typedef logic [1:0] cnt_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // One step along the Gray cycle 00 -> 01 -> 11 -> 10 -> 00.
  // Every 2-bit code is on the cycle, so no recovery state is needed.
  function automatic cnt_t gray_next(input cnt_t cur);
    cnt_t res;
    case (cur)
      2'b00:   res = 2'b01;
      2'b01:   res = 2'b11;
      2'b11:   res = 2'b10;
      2'b10:   res = 2'b00;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/two_bit_counter_next.sv
// Purely combinational next-state function of the 2-bit mode counter.
module two_bit_counter_next
  import two_bit_counter_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       en_i,
  input  logic [1:0] select_i,
  input  logic [1:0] counter_out_i,
  output logic [1:0] nxt_o
);

  // Select the next count from the current count and the requested mode.
  always_comb begin
    nxt_o = cnt_i;
    if (en_i) begin
      case (select_i)
        MODE_UP:   nxt_o = cnt_i + 2'b01;
        MODE_DOWN: nxt_o = cnt_i - 2'b01;
        MODE_GRAY: nxt_o = gray_next(cnt_i);
        MODE_LOAD: nxt_o = counter_out_i;
        default:   nxt_o = cnt_i;
      endcase
    end else begin
      nxt_o = cnt_i;
    end
  end

endmodule

// File: rtl/two_bit_counter.sv
// 2-bit mode-selectable counter with a registered match flag.
// Port names are fixed by the surrounding integration.
module two_bit_counter
  import two_bit_counter_pkg::*;
(
  input  logic       clock,
  input  logic       Reset,
  input  logic       En,
  input  logic [1:0] select,
  input  logic [1:0] Counter_Out,
  output logic       out1
);

  cnt_t cnt;
  cnt_t nxt;
  logic out1_q;
  logic out1_d;

  two_bit_counter_next u_next (
    .cnt_i         (cnt),
    .en_i          (En),
    .select_i      (select),
    .counter_out_i (Counter_Out),
    .nxt_o         (nxt)
  );

  // Match flag: only an enabled edge landing on the target raises it.
  always_comb begin
    out1_d = 1'b0;
    if (En && (nxt == Counter_Out)) begin
      out1_d = 1'b1;
    end else begin
      out1_d = 1'b0;
    end
  end

  // Count and flag registers; reset clears both without waiting for a clock.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      cnt    <= 2'b00;
      out1_q <= 1'b0;
    end else begin
      cnt    <= nxt;
      out1_q <= out1_d;
    end
  end

  assign out1 = out1_q;

endmodule

// File: tb/tb_two_bit_counter.sv
// Directed self-checking bench for two_bit_counter.
module tb_two_bit_counter;

  logic       clock;
  logic       Reset;
  logic       En;
  logic [1:0] select;
  logic [1:0] Counter_Out;
  logic       out1;

  int checks;
  int failures;

  two_bit_counter uut (
    .clock       (clock),
    .Reset       (Reset),
    .En          (En),
    .select      (select),
    .Counter_Out (Counter_Out),
    .out1        (out1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp_cnt, input logic exp_out1);
    check({tag, ".cnt"}, uut.cnt, exp_cnt);
    check({tag, ".out1"}, {1'b0, out1}, {1'b0, exp_out1});
  endtask

  // Drive inputs (just after a falling edge), take one rising edge, sample on the falling edge.
  task automatic step(input logic en, input logic [1:0] sel, input logic [1:0] co,
                      input logic [1:0] exp_cnt, input logic exp_out1, input string tag);
    En          = en;
    select      = sel;
    Counter_Out = co;
    @(posedge clock);
    @(negedge clock);
    check_state(tag, exp_cnt, exp_out1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    Reset       = 1'b1;
    En          = 1'b0;
    select      = 2'b00;
    Counter_Out = 2'b00;

    // Reset state
    #1;
    check_state("rst_init", 2'b00, 1'b0);
    @(negedge clock);
    step(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, "rst_hold0");
    Reset = 1'b0;

    // Up count with wrap, target 11
    step(1'b1, 2'b00, 2'b11, 2'b01, 1'b0, "up1");
    step(1'b1, 2'b00, 2'b11, 2'b10, 1'b0, "up2");
    step(1'b1, 2'b00, 2'b11, 2'b11, 1'b1, "up3");
    step(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, "up4");

    // Down count with wrap, target 01
    step(1'b1, 2'b01, 2'b01, 2'b11, 1'b0, "dn1");
    step(1'b1, 2'b01, 2'b01, 2'b10, 1'b0, "dn2");
    step(1'b1, 2'b01, 2'b01, 2'b01, 1'b1, "dn3");
    step(1'b1, 2'b01, 2'b01, 2'b00, 1'b0, "dn4");

    // Gray cycle, target 10
    step(1'b1, 2'b10, 2'b10, 2'b01, 1'b0, "gr1");
    step(1'b1, 2'b10, 2'b10, 2'b11, 1'b0, "gr2");
    step(1'b1, 2'b10, 2'b10, 2'b10, 1'b1, "gr3");
    step(1'b1, 2'b10, 2'b10, 2'b00, 1'b0, "gr4");

    // Reach 10 by up counting, then assert reset between edges
    step(1'b1, 2'b00, 2'b10, 2'b01, 1'b0, "pre1");
    step(1'b1, 2'b00, 2'b10, 2'b10, 1'b1, "pre2");
    #2;
    Reset = 1'b1;
    #1;
    check_state("rst_async", 2'b00, 1'b0);
    @(negedge clock);
    step(1'b1, 2'b00, 2'b01, 2'b00, 1'b0, "rst_e1");
    step(1'b1, 2'b11, 2'b10, 2'b00, 1'b0, "rst_e2");
    step(1'b1, 2'b10, 2'b01, 2'b00, 1'b0, "rst_e3");
    Reset = 1'b0;

    // First edge after release counts from 00
    step(1'b1, 2'b00, 2'b11, 2'b01, 1'b0, "rel1");

    // Load mode
    step(1'b1, 2'b11, 2'b10, 2'b10, 1'b1, "ld1");
    step(1'b1, 2'b11, 2'b01, 2'b01, 1'b1, "ld2");
    step(1'b1, 2'b11, 2'b10, 2'b10, 1'b1, "ld3");

    // Hold with En=0 while count already equals the target
    step(1'b0, 2'b00, 2'b10, 2'b10, 1'b0, "hold1");
    step(1'b0, 2'b01, 2'b10, 2'b10, 1'b0, "hold2");
    step(1'b0, 2'b10, 2'b10, 2'b10, 1'b0, "hold3");
    step(1'b0, 2'b11, 2'b10, 2'b10, 1'b0, "hold4");

    // Mode change continues from current count: down from 10
    step(1'b1, 2'b01, 2'b00, 2'b01, 1'b0, "mc1");
    step(1'b1, 2'b10, 2'b11, 2'b11, 1'b1, "mc2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/two_bit_counter.md
Name: two_bit_counter

Overview:
- 2-bit mode-selectable counter / finite-state machine with enable, a compare input and a single match flag.
- `Counter_Out` is a 2-bit target/load value supplied by the surrounding logic. The port name is fixed by integration; it is an input.
- `out1` flags that the counter has just reached the target value.
- Used as a small sequencing element in lab-level FSM designs.

Parameters:
- None. The width is fixed at 2 bits.

Ports:
- clock  input  1  rising-edge clock, the only clock domain
- Reset  input  1  asynchronous, active-high reset
- En  input  1  count enable; when 0 the state holds
- select  input  2  mode: 00 up, 01 down, 10 Gray sequence, 11 load
- Counter_Out  input  2  target value for compare; also the load value in mode 11
- out1  output  1  registered match flag

Behaviour:
- State: internal 2-bit register `cnt`. The bench may probe it hierarchically as `uut.cnt`.
- Reset:
  - Reset=1 forces cnt=00 and out1=0 immediately, with no clock edge required.
  - Both stay at those values while Reset is held.
  - Reset has priority over every other input, including mid-sequence.
- Next-state `nxt`, evaluated at each rising clock edge when Reset=0:
  - En=0: nxt = cnt (hold).
  - En=1, select=00: nxt = cnt+1 mod 4 (11 wraps to 00).
  - En=1, select=01: nxt = cnt−1 mod 4 (00 wraps to 11).
  - En=1, select=10: Gray cycle 00→01→11→10→00. All four codes lie on the cycle, so there is no illegal state.
  - En=1, select=11: nxt = Counter_Out (synchronous load).
- Register update: cnt <= nxt.
- Flag: out1 <= En & (nxt == Counter_Out).
  - out1 is high for exactly the cycle following an enabled edge whose new count equals Counter_Out.
  - It is a level, not a latch; it clears on the next edge if the condition fails.
  - En=0 forces out1 <= 0 at the next edge, even if cnt already equals Counter_Out.
  - In load mode with En=1, out1 <= 1 at every edge.
- Mode changes take effect on the very next edge from the current cnt. There is no reset of the sequence on a mode change.
- Counter_Out and select are sampled only at the clock edge. No combinational path exists from inputs to out1.
- Latency: one clock from input change to cnt/out1 update.
- Reset release: the first edge after Reset falls applies normal next-state logic starting from 00.

Decomposition:
- Shared package `two_bit_counter_pkg`:
  - 2-bit mode constants: MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_GRAY=2'b10, MODE_LOAD=2'b11.
  - Optionally a 2-bit state typedef.
- One natural sub-module, `two_bit_counter_next`:
  - Purely combinational next-state function.
  - Inputs: cnt, En, select, Counter_Out.
  - Output: nxt.
- The top level holds the cnt and out1 flops and the compare.

Test Plan:
- Async reset: with cnt=10 mid-count, raise Reset between edges → cnt=00 and out1=0 before the next clock edge; they hold for 3 edges while Reset=1.
- Up count with wrap: Reset released, En=1, select=00, Counter_Out=11 → cnt 01,10,11,00 on edges 1–4; out1 is 0,0,1,0 after those edges.
- Down count: from cnt=00, En=1, select=01, Counter_Out=01 → cnt 11,10,01,00; out1=1 only after edge 3.
- Gray mode: from cnt=00, En=1, select=10, Counter_Out=10 → cnt 01,11,10,00; out1=1 only after edge 3.
- Hold: cnt=10, Counter_Out=10, En=0, any select, 4 edges → cnt stays 10 and out1=0 throughout.
- Load: En=1, select=11, Counter_Out=10 → cnt=10 and out1=1 after one edge. Change Counter_Out to 01 → cnt=01 and out1=1 after the next edge.
